ldm_stm_seq: RTL and testbench
==============================

Name: ldm_stm_seq

Overview:
Multi-register transfer sequencer for LDM/STM, sitting between decode and the register-file write/read ports.
- Walks the 16-bit register list from lowest to highest register.
- For STM, drives a register read code and forwards the read data to memory.
- For LDM, issues one register write per returned word on the WB write port.
- Finishes with an optional base-register writeback.
- All addressing follows ARMv4 P/U/W semantics.

Parameters:
DATA_W, 32, data and address width
WORD_BYTES, 4, address stride per transferred register

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  pipeline enable; 0 freezes all state
i_start  in  1  start pulse; sampled in IDLE only
i_load  in  1  1=LDM, 0=STM
i_pre  in  1  P bit (1=before)
i_up  in  1  U bit (1=increment)
i_wb  in  1  W bit (base writeback)
i_reg_list  in  16  register list, bit n = Rn
i_base  in  32  base register value
i_base_code  in  4  base register number
o_rd_code  out  4  register read code (STM data source)
i_rd_data  in  32  register read data for o_rd_code
o_mem_req  out  1  memory request
o_mem_we  out  1  1=write (STM)
o_mem_addr  out  32  word address
o_mem_wdata  out  32  store data
i_mem_ack  in  1  memory accepts/completes current beat
i_mem_rdata  in  32  load data, valid with ack
o_wr_en  out  1  register write enable (to WB write port)
o_wr_code  out  4  register write number
o_wr_data  out  32  register write data
o_busy  out  1  sequence in progress
o_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; all outputs 0; internal mask, address and final-base registers 0.
- Reset asserted mid-sequence aborts immediately with no further writes.
- `en` = 0: state, mask and address hold; o_mem_req, o_wr_en and o_done are forced 0; i_mem_ack is ignored.
- Start (IDLE, en, i_start):
  - Latch i_load, i_wb, i_base_code and mask = i_reg_list.
  - n = popcount(list).
  - Start address:
    - IA (P=0, U=1): base
    - IB (P=1, U=1): base+4
    - DA (P=0, U=0): base-4n+4
    - DB (P=1, U=0): base-4n
  - Final base = U ? base+4n : base-4n; arithmetic is mod 2^32.
  - If mask = 0, go to DONE with no memory access and no writeback.
  - Otherwise go to XFER.
- XFER:
  - o_mem_req=1, o_mem_we=!load, o_mem_addr = current address.
  - o_rd_code = index of the lowest set bit of mask; o_mem_wdata = i_rd_data.
  - All of these are held stable until ack.
- On ack in XFER:
  - LDM: o_wr_en=1 combinationally in the same cycle, with o_wr_code = current index and o_wr_data = i_mem_rdata.
  - Clear that mask bit; address += 4.
  - If this was the last bit: go to WBACK if wb is latched and not (load and base_code in the original list); else go to DONE.
- Code 15 is treated like any other register. LDM writes to r15 go out on o_wr_code=15; the register file redirects PC. STM of r15 stores whatever the register file returns for code 15.
- WBACK: one cycle with o_wr_en=1, o_wr_code = base_code, o_wr_data = final base; then DONE.
- STM with the base register in the list and wb set: the stored value is the original base, and writeback still occurs.
- DONE: o_done=1 for one cycle, then IDLE.
- o_busy = (state != IDLE).
- i_start while busy is ignored.
- Latency:
  - Empty list: start → done = 2 cycles.
  - Otherwise: 1 + sum of beat latencies + wb + 1.
- Registers are always transferred in ascending address order, lowest register number at lowest address.

Decomposition:
- Shared package ldm_stm_pkg holds:
  - state enum IDLE/XFER/WBACK/DONE
  - WORD_BYTES
  - addressing-mode encoding {P,U} constants
- One sub-module, lsb_prio_enc16: 16-bit lowest-set-bit encoder producing a 4-bit index plus a valid flag.
- popcount stays inline.

Test Plan:
1. LDMIA: base=0x100, list=0x000B, wb=1, base_code=13, ack every cycle, rdata=A,B,C → addresses 0x100, 0x104, 0x108; writes r0=A, r1=B, r3=C; then r13=0x10C; o_done 1 cycle later.
2. STMDB: base=0x200, list=0xC000, wb=1, base_code=13 → addr 0x1F8 with o_rd_code=14, then addr 0x1FC with o_rd_code=15; wdata tracks i_rd_data; writeback r13=0x1F8.
3. LDMIB, base=0x40, list=0x0001, ack delayed 3 cycles → req/addr 0x44 stable for 4 cycles; single write r0 on the ack cycle; no writeback when wb=0.
4. Empty list, STMIA → no o_mem_req, no o_wr_en; o_done 2 cycles after start; i_start pulses during busy are ignored in every other test.
5. LDMDA, base=0x80, list=0x0030, base_code=4, wb=1 → addresses 0x7C (r4), 0x80 (r5); r4 gets the loaded value; no base writeback.
6. Hold en=0 for 2 cycles mid-XFER, then assert rst_n=0 mid-XFER → freeze with outputs 0 while en is low, then immediate IDLE with all outputs 0; next start runs correctly.

Source files
------------

// File: rtl/ldm_stm_pkg.sv
// Shared types and constants for the LDM/STM transfer sequencer.
package ldm_stm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    WBACK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Addressing modes encoded as {P,U}
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

endpackage

// File: rtl/lsb_prio_enc16.sv
// 16-bit lowest-set-bit priority encoder.
module lsb_prio_enc16 (
  input  logic [15:0] req,
  output logic [3:0]  idx,
  output logic        valid
);

  // Scan upward and keep the first set bit found.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (req[i] && !valid) begin
        idx   = i[3:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM multi-register transfer sequencer between decode and the register file.
module ldm_stm_seq
  import ldm_stm_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WORD_BYTES = ldm_stm_pkg::WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              i_start,
  input  logic              i_load,
  input  logic              i_pre,
  input  logic              i_up,
  input  logic              i_wb,
  input  logic [15:0]       i_reg_list,
  input  logic [DATA_W-1:0] i_base,
  input  logic [3:0]        i_base_code,
  output logic [3:0]        o_rd_code,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_wr_en,
  output logic [3:0]        o_wr_code,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done
);

  state_t            state, state_nx;
  logic              load_q, wb_q, base_in_list_q;
  logic [3:0]        base_code_q;
  logic [15:0]       mask;
  logic [DATA_W-1:0] addr, final_base;

  logic [4:0]        cnt;
  logic [DATA_W-1:0] stride, span, start_addr, end_base;
  logic [3:0]        idx;
  logic              idx_valid;
  logic [15:0]       mask_rest;
  logic              last_beat, beat_fire, start_fire;

  lsb_prio_enc16 u_enc (
    .req   (mask),
    .idx   (idx),
    .valid (idx_valid)
  );

  // Popcount of the incoming list and the derived start/final addresses.
  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      cnt = cnt + 5'(i_reg_list[i]);
    end
    stride = DATA_W'(WORD_BYTES);
    span   = DATA_W'(cnt) * stride;
    unique case ({i_pre, i_up})
      MODE_IA: start_addr = i_base;
      MODE_IB: start_addr = i_base + stride;
      MODE_DA: start_addr = i_base - span + stride;
      default: start_addr = i_base - span;
    endcase
    end_base = i_up ? (i_base + span) : (i_base - span);
  end

  assign mask_rest  = mask & (mask - 16'd1);
  assign last_beat  = idx_valid && (mask_rest == '0);
  assign start_fire = en && (state == IDLE) && i_start;
  assign beat_fire  = en && (state == XFER) && i_mem_ack;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Latched operation context, remaining mask and running address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q         <= 1'b0;
      wb_q           <= 1'b0;
      base_in_list_q <= 1'b0;
      base_code_q    <= '0;
      mask           <= '0;
      addr           <= '0;
      final_base     <= '0;
    end else if (start_fire) begin
      load_q         <= i_load;
      wb_q           <= i_wb;
      base_in_list_q <= i_reg_list[i_base_code];
      base_code_q    <= i_base_code;
      mask           <= i_reg_list;
      addr           <= start_addr;
      final_base     <= end_base;
    end else if (beat_fire) begin
      mask <= mask_rest;
      addr <= addr + stride;
    end
  end

  // Next state and outputs; en low freezes state and silences strobes.
  always_comb begin
    state_nx    = state;
    o_rd_code   = '0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_wr_en     = 1'b0;
    o_wr_code   = '0;
    o_wr_data   = '0;
    o_done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) state_nx = (i_reg_list == '0) ? DONE : XFER;
      end
      XFER: begin
        o_mem_req   = idx_valid;
        o_mem_we    = !load_q;
        o_mem_addr  = addr;
        o_rd_code   = idx;
        o_mem_wdata = i_rd_data;
        if (i_mem_ack) begin
          o_wr_en   = load_q;
          o_wr_code = load_q ? idx : '0;
          o_wr_data = load_q ? i_mem_rdata : '0;
          if (last_beat)
            state_nx = (wb_q && !(load_q && base_in_list_q)) ? WBACK : DONE;
        end
      end
      WBACK: begin
        o_wr_en   = 1'b1;
        o_wr_code = base_code_q;
        o_wr_data = final_base;
        state_nx  = DONE;
      end
      default: begin
        o_done   = 1'b1;
        state_nx = IDLE;
      end
    endcase
    if (!en) begin
      state_nx  = state;
      o_mem_req = 1'b0;
      o_wr_en   = 1'b0;
      o_done    = 1'b0;
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Scoreboard bench for ldm_stm_seq: stimulus pushes expected beats/writes/done,
// a monitor pops and compares whenever the DUT presents them.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        rst_n, en, i_start, i_load, i_pre, i_up, i_wb;
  logic [15:0] i_reg_list;
  logic [31:0] i_base, i_rd_data, i_mem_rdata;
  logic [3:0]  i_base_code, o_rd_code, o_wr_code;
  logic        o_mem_req, o_mem_we, i_mem_ack, o_wr_en, o_busy, o_done;
  logic [31:0] o_mem_addr, o_mem_wdata, o_wr_data;

  ldm_stm_seq #(.DATA_W(32), .WORD_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .i_start(i_start), .i_load(i_load),
    .i_pre(i_pre), .i_up(i_up), .i_wb(i_wb), .i_reg_list(i_reg_list),
    .i_base(i_base), .i_base_code(i_base_code), .o_rd_code(o_rd_code),
    .i_rd_data(i_rd_data), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_wr_en(o_wr_en), .o_wr_code(o_wr_code),
    .o_wr_data(o_wr_data), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file and memory contents as seen by the DUT.
  function automatic logic [31:0] reg_val(input logic [3:0] c);
    return {16'hC0DE, c, ~c, c, 4'h5};
  endfunction
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction
  assign i_rd_data   = reg_val(o_rd_code);
  assign i_mem_rdata = mem_val(o_mem_addr);

  typedef struct { logic [31:0] addr; logic we; logic [3:0] code; } beat_t;
  typedef struct { logic [3:0] code; logic [31:0] data; logic is_wb; } wr_t;
  beat_t beat_q[$];
  wr_t   wr_q[$];
  int    done_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: registers ascend from the lowest address of the block.
  task automatic expect_txn(input logic load, pre, up, wb, input logic [15:0] list,
                            input logic [31:0] base, input logic [3:0] bc);
    int n = 0;
    int k = 0;
    logic [31:0] span, lo, a;
    for (int r = 0; r < 16; r++) n += int'(list[r]);
    span = 32'(n) * 32'd4;
    if (up) lo = pre ? base + 32'd4 : base;
    else    lo = pre ? base - span : base - span + 32'd4;
    for (int r = 0; r < 16; r++) begin
      if (list[r]) begin
        a = lo + 32'(4 * k);
        beat_q.push_back('{addr: a, we: !load, code: 4'(r)});
        if (load) wr_q.push_back('{code: 4'(r), data: mem_val(a), is_wb: 1'b0});
        k++;
      end
    end
    if (list != 16'h0 && wb && !(load && list[bc]))
      wr_q.push_back('{code: bc, data: up ? base + span : base - span, is_wb: 1'b1});
    done_q.push_back(1);
  endtask

  // Memory responder: fixed or random ack latency per beat.
  int ack_lat = 0;
  initial begin
    int cnt = 0;
    int cur_lat = 0;
    i_mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (o_mem_req) begin
        if (cnt == 0) cur_lat = (ack_lat < 0) ? int'($urandom_range(0, 3)) : ack_lat;
        if (cnt >= cur_lat) begin i_mem_ack = 1'b1; cnt = 0; end
        else begin i_mem_ack = 1'b0; cnt++; end
      end else begin
        i_mem_ack = 1'($urandom_range(0, 1));
        cnt = 0;
      end
    end
  end

  // Monitor: compares DUT activity against the scoreboard queues.
  initial begin
    int start_cyc = 0;
    int last_evt = 0;
    bit first_req = 1'b0;
    beat_t b;
    wr_t w;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        chk("rst_req", {31'h0, o_mem_req}, 32'h0);
        chk("rst_wr_en", {31'h0, o_wr_en}, 32'h0);
        chk("rst_busy_done", {30'h0, o_busy, o_done}, 32'h0);
        chk("rst_addr", o_mem_addr, 32'h0);
        chk("rst_wdata_we", o_mem_wdata | {31'h0, o_mem_we}, 32'h0);
        chk("rst_codes", {24'h0, o_rd_code, o_wr_code}, 32'h0);
        chk("rst_wr_data", o_wr_data, 32'h0);
      end else if (!en) begin
        chk("freeze_strobes", {29'h0, o_mem_req, o_wr_en, o_done}, 32'h0);
        if (done_q.size() != 0) chk("freeze_busy", {31'h0, o_busy}, 32'h1);
      end else begin
        if (i_start && !o_busy) begin
          start_cyc = cyc; last_evt = cyc; first_req = 1'b1;
        end
        if (o_mem_req) begin
          if (beat_q.size() == 0) chk("req_unexpected", {31'h0, o_mem_req}, 32'h0);
          else begin
            b = beat_q[0];
            chk("mem_addr", o_mem_addr, b.addr);
            chk("mem_we", {31'h0, o_mem_we}, {31'h0, b.we});
            chk("rd_code", {28'h0, o_rd_code}, {28'h0, b.code});
            if (b.we) chk("mem_wdata", o_mem_wdata, reg_val(b.code));
            if (first_req) chk("first_req_cycle", 32'(cyc), 32'(start_cyc + 1));
            first_req = 1'b0;
            if (i_mem_ack) begin
              void'(beat_q.pop_front());
              last_evt = cyc;
            end
          end
        end
        if (o_wr_en) begin
          if (wr_q.size() == 0) chk("wr_unexpected", {31'h0, o_wr_en}, 32'h0);
          else begin
            w = wr_q.pop_front();
            chk("wr_code", {28'h0, o_wr_code}, {28'h0, w.code});
            chk("wr_data", o_wr_data, w.data);
            if (w.is_wb) chk("wb_cycle", 32'(cyc), 32'(last_evt + 1));
            else chk("ld_with_ack", {30'h0, o_mem_req, i_mem_ack}, 32'h3);
            last_evt = cyc;
          end
        end
        if (o_done) begin
          if (done_q.size() == 0) chk("done_unexpected", {31'h0, o_done}, 32'h0);
          else begin
            void'(done_q.pop_front());
            chk("done_cycle", 32'(cyc), 32'(last_evt + 1));
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (o_busy && k < 300) begin @(negedge clk); k++; end
    chk("idle_timeout", {31'h0, o_busy}, 32'h0);
  endtask

  task automatic issue_txn(input logic load, pre, up, wb, input logic [15:0] list,
                           input logic [31:0] base, input logic [3:0] bc, input int lat);
    wait_idle();
    @(negedge clk);
    ack_lat = lat;
    i_load = load; i_pre = pre; i_up = up; i_wb = wb;
    i_reg_list = list; i_base = base; i_base_code = bc;
    i_start = 1'b1;
    expect_txn(load, pre, up, wb, list, base, bc);
    @(negedge clk);
    i_start = 1'b0;
    i_load = 1'($urandom); i_pre = 1'($urandom); i_up = 1'($urandom);
    i_wb = 1'($urandom); i_reg_list = 16'($urandom); i_base = $urandom;
    i_base_code = 4'($urandom);
  endtask

  // Wait for completion, pulsing i_start while busy to confirm it is ignored.
  task automatic finish_txn();
    int k = 0;
    while (done_q.size() != 0 && k < 500) begin
      @(negedge clk);
      if (done_q.size() != 0 && o_busy && !o_done) i_start = ($urandom_range(0, 3) == 0);
      else i_start = 1'b0;
      k++;
    end
    i_start = 1'b0;
    @(negedge clk);
    chk("txn_timeout", 32'(done_q.size()), 32'h0);
    chk("beats_left", 32'(beat_q.size()), 32'h0);
    chk("writes_left", 32'(wr_q.size()), 32'h0);
  endtask

  task automatic run_txn(input logic load, pre, up, wb, input logic [15:0] list,
                         input logic [31:0] base, input logic [3:0] bc, input int lat);
    issue_txn(load, pre, up, wb, list, base, bc, lat);
    finish_txn();
  endtask

  initial begin
    logic [15:0] l;
    logic [3:0]  bc;
    rst_n = 1'b0; en = 1'b1; i_start = 1'b0; i_load = 1'b0; i_pre = 1'b0;
    i_up = 1'b0; i_wb = 1'b0; i_reg_list = '0; i_base = '0; i_base_code = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1, 0, 1, 1, 16'h000B, 32'h0000_0100, 4'd13, 0);  // LDMIA
    run_txn(0, 1, 0, 1, 16'hC000, 32'h0000_0200, 4'd13, 0);  // STMDB
    run_txn(1, 1, 1, 0, 16'h0001, 32'h0000_0040, 4'd2, 3);   // LDMIB, slow ack
    run_txn(0, 0, 1, 1, 16'h0000, 32'h0000_0300, 4'd13, 0);  // empty STMIA
    run_txn(1, 0, 0, 1, 16'h0030, 32'h0000_0080, 4'd4, 0);   // LDMDA, base in list
    run_txn(0, 0, 1, 1, 16'h2011, 32'h0000_0500, 4'd13, 1);  // STM base in list, wb
    run_txn(1, 1, 0, 1, 16'h8001, 32'h0000_0004, 4'd1, 0);   // LDMDB wraps below 0

    // Freeze then reset mid-transfer.
    issue_txn(1, 0, 1, 1, 16'h00FF, 32'h0000_1000, 4'd13, 1);
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    beat_q.delete(); wr_q.delete(); done_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(0, 1, 1, 1, 16'h0421, 32'h0000_2000, 4'd7, 0);

    for (int t = 0; t < 40; t++) begin
      l  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      bc = 4'($urandom);
      if ($urandom_range(0, 2) == 0) l[bc] = 1'b1;
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), l, $urandom, bc, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
